// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell reused for WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_shift;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             s_bit, c_bit;
    logic             last_bit;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift = s_bit;
        end else begin : g_shift_wn
            assign sum_shift = {s_bit, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit  = (state_q == StRun) && (cnt_q == LAST);
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (cnt_q == LAST) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= cin;
                cnt_q   <= '0;
                sum_sr  <= '0;
            end else if (state_q == StRun) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                sum_sr  <= sum_shift;
                carry_q <= c_bit;
                cnt_q   <= cnt_q + CW'(1);
            end
            // Result registers are separate so sum/cout survive the next load and shift.
            if (last_bit) begin
                sum_q  <= sum_shift;
                cout_q <= c_bit;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic carry_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_msb_q <= 1'b0;
        end else if (last_bit) begin
            carry_msb_q <= carry_q;
        end
    end

    // cout_q equals carry_q throughout DONE and stays put afterwards.
    assign ovf = carry_msb_q ^ cout_q;
`endif

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes a single `full_adder` instance across a WIDTH-bit addition, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a valid/ready handshake on both sides. It is the sequencing layer above the 1-bit full adder and trades latency for area: WIDTH cycles per add, one adder cell.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range WIDTH ≥ 1.

Ports:
- `clk`  input  1  — single clock; all state updates on rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_valid`  input  1  — operands `a`, `b`, `cin` are valid.
- `in_ready`  output  1  — controller can accept operands; equals (state == IDLE).
- `a`  input  WIDTH  — operand A.
- `b`  input  WIDTH  — operand B.
- `cin`  input  1  — carry in.
- `out_valid`  output  1  — `sum`/`cout` hold a completed result.
- `out_ready`  input  1  — downstream accepts the result.
- `sum`  output  WIDTH  — result, A + B + cin modulo 2^WIDTH.
- `cout`  output  1  — carry out of bit WIDTH-1.
- `ovf`  output  1  — signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- Exactly one `full_adder` instance. Its inputs are `a_sr[0]`, `b_sr[0]` and `carry_q`. Its outputs are `s_bit` and `c_bit`.
- States:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, load `a_sr`←`a`, `b_sr`←`b`, `carry_q`←`cin`, `cnt`←0, clear `sum_sr`, then go to RUN. With `in_valid`=0, stay in IDLE.
  - RUN: every cycle, `a_sr`/`b_sr` shift right by 1, `sum_sr` ← {`s_bit`, `sum_sr[WIDTH-1:1]`}, `carry_q`←`c_bit`, `cnt`←`cnt`+1. When `cnt` == WIDTH-1, go to DONE.
  - DONE: `out_valid`=1. `sum`=`sum_sr`, `cout`=`carry_q`, and both are stable. On `out_valid && out_ready`, go to IDLE. Otherwise hold.
- `cnt` is $clog2(WIDTH+1) bits wide and never wraps during a transaction.
- In RUN and DONE, `in_valid`, `a`, `b` and `cin` are ignored. Operands are captured only at the accept edge.
- `sum`/`cout` keep their last value through IDLE and RUN until the next result is produced. Only `out_valid` qualifies them.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1 while `rst` is high.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - `cnt`, `carry_q` and all shift registers are 0.
- Latency: if operands are accepted at edge E0, `out_valid` rises after edge E0+WIDTH. For WIDTH=1, it rises after E0+1.
- Throughput: at most one add per WIDTH+2 cycles. The result handshake and the next accept cannot share an edge; `in_ready` returns high the cycle after the output handshake.
- Back-pressure: with `out_ready`=0, DONE holds indefinitely and outputs do not change.
- `out_ready` high before DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts immediately (asynchronously) to the reset values. The partial result is discarded.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - Adds a `carry_msb_q` register that captures the carry into bit WIDTH-1, i.e. `carry_q` on the final RUN cycle.
  - Adds the `ovf` output, `ovf` = `carry_msb_q` ^ `carry_q`, valid with `out_valid`.
  - `ovf` resets to 0.
- Undefined: no `ovf` port and no `carry_msb_q` register. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 → `sum`=0x00, `cout`=0, `out_valid` rising exactly 8 cycles after the accept edge.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0; then a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `ovf`=1.
- WIDTH=8, a=0xA5, b=0x5A, cin=1, `out_ready` held 0 for 5 cycles in DONE → `sum`=0x00, `cout`=1 held stable, `in_ready`=0 throughout; after the handshake, `in_ready`=1 the next cycle.
- WIDTH=8, change `a`/`b`/`cin` and pulse `in_valid` during RUN → result still reflects the originally captured operands.
- WIDTH=8, assert `rst` at RUN `cnt`=3 → `out_valid`=0, `sum`=0, `cout`=0 immediately; the next add, 0x12+0x34 cin=0, gives 0x46.
- WIDTH=1, all 8 {a,b,cin} combinations → {`cout`,`sum`} = 00, 01, 01, 10, 01, 10, 10, 11 in order a,b,cin = 000…111.
